// File: rtl/if_fetch_unit.sv
// if_fetch_unit: IF stage owning the PC; fetches one instruction per
// ISSUE/WAIT/HOLD round over a req/ready instruction-memory handshake.
//
// Ports:
//   IFU_i_clk, IFU_i_rst_n     clock, async active-low reset
//   IFU_i_nPC                  next PC from NPC, taken on accept
//   IFU_i_Stall                downstream not ready (hold presented instr)
//   IFU_i_ExcReq               exception redirect pulse to HANDLER_PC
//   IFU_o_IMReq/IFU_o_IMAddr   memory read request and word address
//   IFU_i_IMReady/IFU_i_IMData memory response
//   IFU_o_PC/Instr/Valid/ExcCode  bundle to IF/ID (ExcCode 4 = AdEL)
//
// Build option: define IFU_ADDR_CHECK_EN to enable the alignment and
// range checks that turn an illegal PC into a nop carrying AdEL.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
  parameter logic [31:0] IM_BASE    = 32'h0000_3000,
  parameter logic [31:0] IM_TOP     = 32'h0000_6FFC
) (
  input  logic        IFU_i_clk,
  input  logic        IFU_i_rst_n,
  input  logic [31:0] IFU_i_nPC,
  input  logic        IFU_i_Stall,
  input  logic        IFU_i_ExcReq,
  output logic        IFU_o_IMReq,
  output logic [31:0] IFU_o_IMAddr,
  input  logic        IFU_i_IMReady,
  input  logic [31:0] IFU_i_IMData,
  output logic [31:0] IFU_o_PC,
  output logic [31:0] IFU_o_Instr,
  output logic        IFU_o_Valid,
  output logic [4:0]  IFU_o_ExcCode
);

  typedef enum logic [1:0] {
    S_ISSUE = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;
  logic [4:0]  exc_q, exc_d;
  logic        pend_q, pend_d;
  logic        pc_ok;

`ifdef IFU_ADDR_CHECK_EN
  assign pc_ok = (pc_q[1:0] == 2'b00)
              && (pc_q >= IM_BASE)
              && (pc_q <= IM_TOP);
`else
  logic unused_range;
  assign unused_range = ^{IM_BASE, IM_TOP};
  assign pc_ok = 1'b1;
`endif

  // The request lives for the whole WAIT state, so it can never be
  // withdrawn early and it drops with the async reset of the state.
  assign IFU_o_IMReq   = (state_q == S_WAIT);
  assign IFU_o_IMAddr  = {pc_q[31:2], 2'b00};
  assign IFU_o_PC      = pc_q;
  assign IFU_o_Instr   = instr_q;
  assign IFU_o_Valid   = valid_q;
  assign IFU_o_ExcCode = exc_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    exc_d   = exc_q;
    pend_d  = pend_q;
    unique case (state_q)
      S_ISSUE: begin
        if (IFU_i_ExcReq) begin
          pc_d    = HANDLER_PC;
          valid_d = 1'b0;
        end else if (pc_ok) begin
          state_d = S_WAIT;
        end else begin
          instr_d = 32'h0;
          exc_d   = EXC_ADEL;
          valid_d = 1'b1;
          state_d = S_HOLD;
        end
      end
      S_WAIT: begin
        if (IFU_i_IMReady) begin
          // A redirect seen during the wait throws the data away.
          if (pend_q || IFU_i_ExcReq) begin
            pc_d    = HANDLER_PC;
            pend_d  = 1'b0;
            valid_d = 1'b0;
            state_d = S_ISSUE;
          end else begin
            instr_d = IFU_i_IMData;
            exc_d   = EXC_NONE;
            valid_d = 1'b1;
            state_d = S_HOLD;
          end
        end else if (IFU_i_ExcReq) begin
          pend_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (IFU_i_ExcReq) begin
          pc_d    = HANDLER_PC;
          valid_d = 1'b0;
          state_d = S_ISSUE;
        end else if (!IFU_i_Stall) begin
          pc_d    = IFU_i_nPC;
          valid_d = 1'b0;
          state_d = S_ISSUE;
        end
      end
      default: begin
        valid_d = 1'b0;
        pend_d  = 1'b0;
        state_d = S_ISSUE;
      end
    endcase
  end

  always_ff @(posedge IFU_i_clk or negedge IFU_i_rst_n) begin
    if (!IFU_i_rst_n) begin
      state_q <= S_ISSUE;
      pc_q    <= RESET_PC;
      instr_q <= 32'h0;
      valid_q <= 1'b0;
      exc_q   <= EXC_NONE;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      exc_q   <= exc_d;
      pend_q  <= pend_d;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed table-driven bench for if_fetch_unit
// with hand-written redirect and reset sequences.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] npc = 32'h0;
  logic        stall = 1'b0;
  logic        exc = 1'b0;
  logic        ready = 1'b0;
  logic [31:0] imdata = 32'h0;
  logic        im_req;
  logic [31:0] im_addr;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        valid;
  logic [4:0]  exc_code;

  int errors = 0;
  int checks = 0;

  if_fetch_unit dut (
    .IFU_i_clk    (clk),
    .IFU_i_rst_n  (rst_n),
    .IFU_i_nPC    (npc),
    .IFU_i_Stall  (stall),
    .IFU_i_ExcReq (exc),
    .IFU_o_IMReq  (im_req),
    .IFU_o_IMAddr (im_addr),
    .IFU_i_IMReady(ready),
    .IFU_i_IMData (imdata),
    .IFU_o_PC     (pc),
    .IFU_o_Instr  (instr),
    .IFU_o_Valid  (valid),
    .IFU_o_ExcCode(exc_code)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] pc;
    int          w;
    int          s;
    logic [31:0] npc;
  } vec_t;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  function automatic bit pc_legal(input logic [31:0] p);
`ifdef IFU_ADDR_CHECK_EN
    return (p[1:0] == 2'b00) && (p >= 32'h3000) && (p <= 32'h6FFC);
`else
    return 1'b1;
`endif
  endfunction

  // Entered at a negedge with the DUT in ISSUE at v.pc.
  task automatic fetch(input vec_t v);
    logic [31:0] a;
    logic [31:0] ei;
    logic [31:0] ee;
    a = {v.pc[31:2], 2'b00};
    chk("issue_pc", pc, v.pc);
    chk("issue_req", {31'b0, im_req}, 32'd0);
    chk("issue_valid", {31'b0, valid}, 32'd0);
    @(negedge clk);
    if (pc_legal(v.pc)) begin
      for (int k = 0; k <= v.w; k++) begin
        chk("wait_req", {31'b0, im_req}, 32'd1);
        chk("wait_addr", im_addr, a);
        chk("wait_valid", {31'b0, valid}, 32'd0);
        ready = (k == v.w);
        imdata = ready ? mem_word(a) : 32'hDEAD_BEEF;
        @(negedge clk);
      end
      ready = 1'b0;
      ei = mem_word(a);
      ee = 32'd0;
    end else begin
      ei = 32'd0;
      ee = 32'd4;
    end
    chk("hold_valid", {31'b0, valid}, 32'd1);
    chk("hold_pc", pc, v.pc);
    chk("hold_instr", instr, ei);
    chk("hold_exc", {27'b0, exc_code}, ee);
    chk("hold_req", {31'b0, im_req}, 32'd0);
    for (int k = 0; k < v.s; k++) begin
      stall = 1'b1;
      npc = 32'hBAD0_0000;
      @(negedge clk);
      chk("stall_valid", {31'b0, valid}, 32'd1);
      chk("stall_pc", pc, v.pc);
      chk("stall_instr", instr, ei);
      chk("stall_req", {31'b0, im_req}, 32'd0);
    end
    stall = 1'b0;
    npc = v.npc;
    @(negedge clk);
    chk("accept_valid", {31'b0, valid}, 32'd0);
    chk("accept_pc", pc, v.npc);
  endtask

  vec_t tbl [10];

  initial begin
    tbl[0] = '{32'h3000, 1, 0, 32'h3004};
    tbl[1] = '{32'h3004, 1, 4, 32'h3008};
    tbl[2] = '{32'h3008, 0, 0, 32'h3010};
    tbl[3] = '{32'h3010, 5, 0, 32'h3014};
    tbl[4] = '{32'h3014, 2, 1, 32'h6FFC};
    tbl[5] = '{32'h6FFC, 0, 0, 32'h3002};
    tbl[6] = '{32'h3002, 0, 2, 32'h7000};
    tbl[7] = '{32'h7000, 1, 0, 32'hFFFF_FFFC};
    tbl[8] = '{32'hFFFF_FFFC, 0, 0, 32'h2FFC};
    tbl[9] = '{32'h2FFC, 0, 0, 32'h3020};

    repeat (2) @(negedge clk);
    chk("rst_req", {31'b0, im_req}, 32'd0);
    chk("rst_valid", {31'b0, valid}, 32'd0);
    chk("rst_pc", pc, 32'h3000);
    chk("rst_instr", instr, 32'd0);
    chk("rst_exc", {27'b0, exc_code}, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) fetch(tbl[i]);

    // Redirect during WAIT; the late data must be dropped.
    chk("excw_pc", pc, 32'h3020);
    @(negedge clk);
    chk("excw_req", {31'b0, im_req}, 32'd1);
    chk("excw_addr", im_addr, 32'h3020);
    exc = 1'b1;
    @(negedge clk);
    exc = 1'b0;
    chk("excw_req_held", {31'b0, im_req}, 32'd1);
    chk("excw_addr_held", im_addr, 32'h3020);
    @(negedge clk);
    chk("excw_req_held2", {31'b0, im_req}, 32'd1);
    ready = 1'b1;
    imdata = mem_word(32'h3020);
    @(negedge clk);
    ready = 1'b0;
    chk("excw_valid", {31'b0, valid}, 32'd0);
    chk("excw_newpc", pc, 32'h4180);
    chk("excw_req_off", {31'b0, im_req}, 32'd0);
    fetch('{32'h4180, 0, 0, 32'h3040});

    // Redirect coincident with IMReady.
    @(negedge clk);
    chk("excr_req", {31'b0, im_req}, 32'd1);
    ready = 1'b1;
    exc = 1'b1;
    imdata = mem_word(32'h3040);
    @(negedge clk);
    ready = 1'b0;
    exc = 1'b0;
    chk("excr_valid", {31'b0, valid}, 32'd0);
    chk("excr_pc", pc, 32'h4180);
    chk("excr_req_off", {31'b0, im_req}, 32'd0);

    // Redirect in HOLD overrides Stall.
    @(negedge clk);
    ready = 1'b1;
    imdata = mem_word(32'h4180);
    @(negedge clk);
    ready = 1'b0;
    chk("exch_valid", {31'b0, valid}, 32'd1);
    stall = 1'b1;
    exc = 1'b1;
    @(negedge clk);
    stall = 1'b0;
    exc = 1'b0;
    chk("exch_valid_off", {31'b0, valid}, 32'd0);
    chk("exch_pc", pc, 32'h4180);
    fetch('{32'h4180, 0, 0, 32'h3060});

    // Redirect in ISSUE suppresses the request.
    exc = 1'b1;
    @(negedge clk);
    exc = 1'b0;
    chk("exci_pc", pc, 32'h4180);
    chk("exci_req", {31'b0, im_req}, 32'd0);
    chk("exci_valid", {31'b0, valid}, 32'd0);
    fetch('{32'h4180, 0, 0, 32'h3008});

    // Async reset in the middle of a WAIT.
    @(negedge clk);
    chk("rstw_req", {31'b0, im_req}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstw_req_off", {31'b0, im_req}, 32'd0);
    chk("rstw_valid", {31'b0, valid}, 32'd0);
    chk("rstw_pc", pc, 32'h3000);
    @(negedge clk);
    rst_n = 1'b1;
    fetch('{32'h3000, 1, 0, 32'h3004});
    fetch('{32'h3004, 0, 0, 32'h3008});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
